mc_control: RTL
===============

Name: mc_control

Overview:
- Multi-cycle sequencing controller for the MIPS datapath.
- Replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives the existing PC, register-file, data-memory and mux selects, plus the 3-bit ula_operation consumed by ula_control.
- Waits on a memory-ready handshake so a shared, variable-latency unified memory can be used.

Parameters:
- USE_MEM_READY, 1: when 0, mem_ready is ignored and treated as constant 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
- PCWrite  out  1  unconditional PC load.
- BranchOp  out  2  00 none, 01 beq, 10 bne; fed to the existing branch selector as conditional PC write.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction-register load.
- MemtoReg  out  1  register write-data select: 1 = MDR.
- RegDst  out  1  write-register select: 1 = rd.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ULA A select: 0 = PC, 1 = ReadData1.
- ALUSrcB  out  2  ULA B select: 00 ReadData2, 01 const 4, 10 sext, 11 sext<<2.
- ula_operation  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- PCSource  out  2  next-PC select: 00 ULA result, 01 ALUOut, 10 jump target.
- state_o  out  4  current state, for debug.
- trap  out  1  illegal-opcode flag; constant 0 unless the optional feature is enabled.

Behaviour:
- State register is 4 bits, asynchronous reset to FETCH.
- Outputs decode combinationally from state (and mem_ready where noted). Any signal not listed for a state is 0.
- While reset=1, all write/strobe outputs are forced to 0 and state_o=0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, slti=001010, j=000010.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ula_operation=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ula_operation=000 (branch target into ALUOut).
  - lw/sw -> MEM_ADDR; R -> R_EXEC; beq/bne -> BRANCH; addi/andi/ori/slti -> I_EXEC; j -> JUMP.
  - Other opcodes -> FETCH, executed as a NOP.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ula_operation=000. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ (3): MemRead=1, IorD=1. Holds while mem_ready=0; goes to MEM_WB when mem_ready=1.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Holds while mem_ready=0; goes to FETCH when mem_ready=1.
  - MemWrite stays asserted for the entire wait.
- R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ula_operation=010. Next: R_WB.
- R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ula_operation=001, PCSource=01.
  - BranchOp=01 for beq, 10 for bne. Next: FETCH.
- I_EXEC (9): ALUSrcA=1, ALUSrcB=10. ula_operation: addi 000, andi 011, ori 100, slti 101. Next: I_WB.
- I_WB (10): RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
- JUMP (11): PCWrite=1, PCSource=10. Next: FETCH.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R 4, I-type 4, beq/bne 3, j 3. Each 0-cycle of mem_ready in a waiting state adds exactly one cycle.
- Opcode is sampled in DECODE and in the states that branch on it. The IR must not change after FETCH completes.
- Reset mid-instruction aborts it with no partial write: strobes drop asynchronously, and the next access is a FETCH.
- Unused encodings 12-15 (13-15 when the trap is enabled) return to FETCH on the next clock.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP (12).
  - In TRAP, trap=1 and all strobes are 0.
  - TRAP is held until reset.
- Undefined: an unrecognised opcode returns to FETCH (NOP), trap is tied to 0, and encoding 12 is unused.

Test Plan:
- Reset asserted mid-cycle, released -> state_o=0, MemRead=1, IRWrite=1 (mem_ready=1), RegWrite=MemWrite=0.
- R-type add with mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. ula_operation=010 in state 6.
- lw with mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. RegWrite and MemtoReg pulse once, in state 4.
- bne -> state 8 drives BranchOp=10, PCSource=01, ula_operation=001. j -> PCWrite=1 with PCSource=10 in state 11.
- sw with reset asserted in MEM_WRITE -> MemWrite falls the same cycle. After release, state_o=0.
- opcode 111111: without the macro -> 0,1,0 and trap=0. With MC_ILLEGAL_TRAP_EN -> state 12, trap=1, held for 10 cycles until reset.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle Moore sequencing controller for the MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// waits on mem_ready for the shared unified memory. Outputs decode from the
// current state (plus mem_ready in FETCH and opcode in the branching states).
// Optional build macro MC_ILLEGAL_TRAP_EN: an unknown opcode parks the FSM in
// TRAP (12) with trap=1 until reset; otherwise it executes as a NOP.
//
// state | meaning
// 0  FETCH     | read instruction at PC, PC += 4 when memory ready
// 1  DECODE    | branch target into ALUOut, dispatch on opcode
// 2  MEM_ADDR  | ALUOut = rs + sext(imm)
// 3  MEM_READ  | data read at ALUOut, wait for memory
// 4  MEM_WB    | MDR -> rt
// 5  MEM_WRITE | data write at ALUOut, wait for memory
// 6  R_EXEC    | rs op rt
// 7  R_WB      | ALUOut -> rd
// 8  BRANCH    | compare rs/rt, conditional PC load from ALUOut
// 9  I_EXEC    | rs op sext(imm)
// 10 I_WB      | ALUOut -> rt
// 11 JUMP      | PC = jump target
// 12 TRAP      | illegal opcode, held until reset (trap build only)

module mc_control #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic [1:0] BranchOp,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ula_operation,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state;
    logic   ready;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    // State register; unknown opcodes and unused encodings fall back to FETCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:     if (ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:                      state <= S_MEM_ADDR;
                        OP_R:                              state <= S_R_EXEC;
                        OP_BEQ, OP_BNE:                    state <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= S_I_EXEC;
                        OP_J:                              state <= S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                        default:                           state <= S_TRAP;
`else
                        default:                           state <= S_FETCH;
`endif
                    endcase
                end
                S_MEM_ADDR:  state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (ready) state <= S_MEM_WB;
                S_MEM_WRITE: if (ready) state <= S_FETCH;
                S_R_EXEC:    state <= S_R_WB;
                S_I_EXEC:    state <= S_I_WB;
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:      state <= S_TRAP;
`endif
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; strobes are gated by reset so an abort never writes.
    always_comb begin
        PCWrite       = 1'b0;
        BranchOp      = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ula_operation = 3'b000;
        PCSource      = 2'b00;
        trap          = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = ready;
                PCWrite = ready;
            end
            S_DECODE:    ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA       = 1'b1;
                ula_operation = 3'b010;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ula_operation = 3'b001;
                PCSource      = 2'b01;
                BranchOp      = (opcode == OP_BNE) ? 2'b10 : 2'b01;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: ula_operation = 3'b011;
                    OP_ORI:  ula_operation = 3'b100;
                    OP_SLTI: ula_operation = 3'b101;
                    default: ula_operation = 3'b000;
                endcase
            end
            S_I_WB:      RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:      trap = 1'b1;
`endif
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            BranchOp = 2'b00;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state_o = reset ? 4'd0 : state;

endmodule
